sprite_plotter: RTL and testbench

- Frame-synchronous erase/redraw controller for one square sprite on the 160x120, 3-bit-colour VGA adapter.
- Sits directly downstream of the per-axis position stages (x and y bouncing-position registers).
- Once per frame it erases the sprite at its old position, pulses `update` so the position stages advance, latches the new position and redraws.
- Drives the VGA adapter `x`/`y`/`colour`/`plot` inputs.

---
 rtl/sprite_plotter.sv | 156 +++++++++++++++
 tb/tb_sprite_plotter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_plotter.sv
// ----------------------------------------------------------------------------
// sprite_plotter
//
// Frame-synchronous erase/redraw controller for one SIZE x SIZE sprite on the
// 160x120, 3-bit-colour VGA adapter. It sits downstream of the x/y bouncing
// position stages. Once per frame it erases the sprite at its old position and
// pulses `update` so that the position stages step. It then latches the new
// position and redraws the sprite there.
//
// Ports
//   clk         system clock, all state on rising edge
//   reset       synchronous, active-high reset
//   xin         sprite top-left x from the x position stage (0..124)
//   yin         sprite top-left y from the y position stage (0..116)
//   colour_in   sprite colour
//   vga_x       pixel x to VGA adapter
//   vga_y       pixel y to VGA adapter
//   vga_colour  pixel colour to VGA adapter
//   plot        VGA write-enable, one pixel per cycle while high
//   update      one-cycle step enable for the position stages
//   busy        high whenever the controller is not IDLE
//
// State  | meaning
// -------+-------------------------------------------------------------
// LATCH  | capture xin/yin/colour_in, clear pixel counter (1 cycle)
// DRAW   | plot SIZE*SIZE pixels in saved colour at saved position
// IDLE   | wait for the frame tick
// ERASE  | plot SIZE*SIZE pixels in BG_COLOUR at saved position
// UPDATE | pulse update so the position stages step (1 cycle)
// ----------------------------------------------------------------------------
module sprite_plotter #(
   parameter int          SIZE        = 4,
   parameter int          FRAME_COUNT = 833334,
   parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] xin,
   input  logic [6:0] yin,
   input  logic [2:0] colour_in,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       plot,
   output logic       update,
   output logic       busy
);

   localparam int NPIX  = SIZE * SIZE;
   localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int FW    = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1;
   localparam int LOG_S = $clog2(SIZE);

   localparam logic [PW-1:0] PIX_LAST   = PW'(NPIX - 1);
   localparam logic [PW-1:0] PIX_MASK   = PW'(SIZE - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_COUNT - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LATCH  = 3'd1;
   localparam logic [2:0] S_DRAW   = 3'd2;
   localparam logic [2:0] S_ERASE  = 3'd3;
   localparam logic [2:0] S_UPDATE = 3'd4;

   logic [2:0]    state;
   logic [FW-1:0] frame_cnt;
   logic [PW-1:0] pix_cnt;
   logic [6:0]    saved_x;
   logic [6:0]    saved_y;
   logic [2:0]    saved_colour;

   logic          tick;
   logic          pix_last;
   logic [7:0]    px;
   logic [6:0]    py;

   assign tick     = (frame_cnt == FRAME_LAST);
   assign pix_last = (pix_cnt == PIX_LAST);

   // SIZE is a power of two, so row-major mod/div reduce to mask/shift.
   assign px = 8'(pix_cnt & PIX_MASK);
   assign py = 7'(pix_cnt >> LOG_S);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_LATCH;
         frame_cnt    <= '0;
         pix_cnt      <= '0;
         saved_x      <= '0;
         saved_y      <= '0;
         saved_colour <= '0;
      end else begin
         frame_cnt <= tick ? '0 : frame_cnt + 1'b1;

         case (state)
            S_LATCH: begin
               saved_x      <= xin;
               saved_y      <= yin;
               saved_colour <= colour_in;
               pix_cnt      <= '0;
               state        <= S_DRAW;
            end
            S_DRAW: begin
               if (pix_last) begin
                  pix_cnt <= '0;
                  state   <= S_IDLE;
               end else begin
                  pix_cnt <= pix_cnt + 1'b1;
               end
            end
            S_IDLE: begin
               // A tick seen in any other state is dropped on purpose.
               if (tick) begin
                  pix_cnt <= '0;
                  state   <= S_ERASE;
               end
            end
            S_ERASE: begin
               if (pix_last) begin
                  pix_cnt <= '0;
                  state   <= S_UPDATE;
               end else begin
                  pix_cnt <= pix_cnt + 1'b1;
               end
            end
            S_UPDATE: begin
               state <= S_LATCH;
            end
            default: begin
               state <= S_LATCH;
            end
         endcase
      end
   end

   // Outputs decode registered state only; reset forces them quiet even in
   // the cycles before the reset edge has been seen.
   always_comb begin
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      plot       = 1'b0;
      update     = 1'b0;
      busy       = 1'b0;
      if (!reset) begin
         busy   = (state != S_IDLE);
         update = (state == S_UPDATE);
         if (state == S_DRAW || state == S_ERASE) begin
            plot       = 1'b1;
            vga_x      = {1'b0, saved_x} + px;
            vga_y      = saved_y + py;
            vga_colour = (state == S_DRAW) ? saved_colour : BG_COLOUR;
         end
      end
   end

endmodule

// File: tb/tb_sprite_plotter.sv
// ----------------------------------------------------------------------------
// tb_sprite_plotter
//
// Directed bench for sprite_plotter with SIZE=4, FRAME_COUNT=64. "Cycle n"
// is the n-th clock after the first cycle with reset low (cycle 0 = LATCH).
// Outputs are sampled 1 time unit after each rising edge; inputs are driven
// right after sampling, so a value set in cycle n is seen by the edge ending
// cycle n.
// ----------------------------------------------------------------------------
module tb_sprite_plotter;

   logic       clk;
   logic       reset;
   logic [6:0] xin;
   logic [6:0] yin;
   logic [2:0] colour_in;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       plot;
   logic       update;
   logic       busy;

   int n_chk;
   int n_err;
   int cyc;
   int upd_cnt;

   sprite_plotter #(
      .SIZE        (4),
      .FRAME_COUNT (64),
      .BG_COLOUR   (3'b000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .xin        (xin),
      .yin        (yin),
      .colour_in  (colour_in),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .plot       (plot),
      .update     (update),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset && update)
         upd_cnt <= upd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic scramble();
      xin       = 7'($urandom_range(0, 124));
      yin       = 7'($urandom_range(0, 116));
      colour_in = 3'($urandom_range(0, 7));
   endtask

   // Steps through n pixel cycles, checking each against the row-major model.
   task automatic pix_check(input string tag, input int n, input int x0, input int y0,
                            input int col, input bit tog);
      for (int k = 0; k < n; k++) begin
         step();
         chk({tag, ".plot"},   32'(plot),       32'd1);
         chk({tag, ".update"}, 32'(update),     32'd0);
         chk({tag, ".x"},      32'(vga_x),      32'(x0 + (k % 4)));
         chk({tag, ".y"},      32'(vga_y),      32'(y0 + (k / 4)));
         chk({tag, ".col"},    32'(vga_colour), 32'(col));
         if (tog) scramble();
      end
   endtask

   task automatic idle_until(input int target, input bit tog);
      while (cyc < target) begin
         step();
         chk("idle.plot", 32'(plot), 32'd0);
         chk("idle.busy", 32'(busy), 32'd0);
         if (tog) scramble();
      end
   endtask

   initial begin
      n_chk     = 0;
      n_err     = 0;
      cyc       = 0;
      upd_cnt   = 0;
      reset     = 1'b1;
      xin       = 7'd10;
      yin       = 7'd20;
      colour_in = 3'b100;

      repeat (3) @(posedge clk);
      #1;
      chk("rst.plot",   32'(plot),   32'd0);
      chk("rst.update", 32'(update), 32'd0);
      chk("rst.busy",   32'(busy),   32'd0);
      chk("rst.x",      32'(vga_x),  32'd0);
      chk("rst.y",      32'(vga_y),  32'd0);
      chk("rst.col",    32'(vga_colour), 32'd0);

      // Cycle 0: LATCH.
      reset = 1'b0;
      #1;
      cyc = 0;
      chk("latch0.busy", 32'(busy), 32'd1);
      chk("latch0.plot", 32'(plot), 32'd0);

      pix_check("draw0", 16, 10, 20, 4, 1'b0);          // cycles 1..16
      step();                                           // 17
      chk("draw0.done.plot", 32'(plot), 32'd0);
      chk("draw0.done.busy", 32'(busy), 32'd0);
      idle_until(63, 1'b0);

      pix_check("erase0", 16, 10, 20, 0, 1'b0);         // 64..79
      step();                                           // 80
      chk("upd0.update", 32'(update), 32'd1);
      chk("upd0.plot",   32'(plot),   32'd0);
      chk("upd0.busy",   32'(busy),   32'd1);
      step();                                           // 81 LATCH
      chk("latch1.update", 32'(update), 32'd0);
      chk("latch1.plot",   32'(plot),   32'd0);
      xin = 7'd11;
      pix_check("draw1", 16, 11, 20, 4, 1'b1);          // 82..97, inputs toggling
      step();                                           // 98
      chk("draw1.done.busy", 32'(busy), 32'd0);
      scramble();
      idle_until(127, 1'b1);

      pix_check("erase1", 16, 11, 20, 0, 1'b1);         // 128..143
      step();                                           // 144
      chk("upd1.update", 32'(update), 32'd1);
      scramble();
      step();                                           // 145 LATCH
      xin       = 7'd124;
      yin       = 7'd116;
      colour_in = 3'b011;
      pix_check("edge", 16, 124, 116, 3, 1'b1);         // 146..161, last (127,119)
      step();                                           // 162
      chk("edge.done.busy", 32'(busy), 32'd0);
      chk("upd.count2", 32'(upd_cnt), 32'd2);
      idle_until(191, 1'b0);

      pix_check("erase2", 16, 124, 116, 0, 1'b0);       // 192..207
      step();                                           // 208
      chk("upd2.update", 32'(update), 32'd1);
      step();                                           // 209 LATCH
      xin       = 7'd30;
      yin       = 7'd40;
      colour_in = 3'b101;
      pix_check("draw3", 6, 30, 40, 5, 1'b0);           // 210..215
      step();                                           // 216: pixel 7
      chk("draw3.p7.plot", 32'(plot),  32'd1);
      chk("draw3.p7.x",    32'(vga_x), 32'd32);
      chk("draw3.p7.y",    32'(vga_y), 32'd41);
      reset     = 1'b1;
      xin       = 7'd50;
      yin       = 7'd60;
      colour_in = 3'b110;
      step();                                           // 217, reset seen
      chk("midrst.plot",   32'(plot),   32'd0);
      chk("midrst.busy",   32'(busy),   32'd0);
      chk("midrst.update", 32'(update), 32'd0);
      reset = 1'b0;
      #1;
      cyc = 0;
      chk("midrst.latch.busy", 32'(busy), 32'd1);
      chk("midrst.latch.plot", 32'(plot), 32'd0);
      pix_check("redraw", 16, 50, 60, 6, 1'b0);
      step();
      chk("redraw.done.busy", 32'(busy), 32'd0);
      chk("upd.count3", 32'(upd_cnt), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
